// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state sequencer driving an external 8-bit ALU
module alu_sequencer #(
    parameter int unsigned DEC_SUPPORT = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       REQ,
    input  logic [3:0] OP,
    input  logic [7:0] OPA,
    input  logic [7:0] OPB,
    input  logic       C_IN,
    input  logic       D_FLAG,
    output logic [7:0] ALU_A,
    output logic [7:0] ALU_B,
    output logic       ALU_CIN,
    output logic       SUMS,
    output logic       ANDS,
    output logic       ORS,
    output logic       EORS,
    output logic       SRS,
    output logic       DEC_EN,
    input  logic [7:0] ALU_RESULT,
    input  logic       ALU_COUT,
    input  logic       ALU_OF,
    output logic       BUSY,
    output logic       DONE,
    output logic       WE,
    output logic       ERR,
    output logic [7:0] RESULT,
    output logic       N,
    output logic       Z,
    output logic       C,
    output logic       V
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_DONE} state_t;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_ASL = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

    state_t     state, next_state;
    logic [3:0] op_q;
    logic [7:0] opa_q, opb_q;
    logic       cin_q, dflag_q;

    logic [3:0] src_op;
    logic [7:0] src_a, src_b;
    logic       src_cin, src_dec, dec_mode;
    logic [7:0] drv_a, drv_b;
    logic       drv_cin, drv_sums, drv_ands, drv_ors, drv_eors, drv_srs, drv_dec;
    logic       drive_active;

    logic       op_legal;
    logic [7:0] fin_res;
    logic       fin_c, fin_v;

    always_ff @(posedge CLK) begin
        if (!RST_N) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (REQ) next_state = S_LOAD;
            S_LOAD: next_state = S_EXEC;
            S_EXEC: next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    assign drive_active = (next_state == S_LOAD) || (next_state == S_EXEC);

    // Drive registers load on the accepting edge, so they must see the live inputs there.
    always_comb begin
        src_op   = (state == S_IDLE) ? OP     : op_q;
        src_a    = (state == S_IDLE) ? OPA    : opa_q;
        src_b    = (state == S_IDLE) ? OPB    : opb_q;
        src_cin  = (state == S_IDLE) ? C_IN   : cin_q;
        src_dec  = (state == S_IDLE) ? D_FLAG : dflag_q;
        dec_mode = (DEC_SUPPORT != 0) && src_dec;
        drv_a    = src_a;
        drv_b    = 8'h00;
        drv_cin  = 1'b0;
        drv_sums = 1'b0;
        drv_ands = 1'b0;
        drv_ors  = 1'b0;
        drv_eors = 1'b0;
        drv_srs  = 1'b0;
        drv_dec  = 1'b0;
        case (src_op)
            OP_ADC: begin
                drv_sums = 1'b1;
                drv_b    = src_b;
                drv_cin  = src_cin;
                drv_dec  = dec_mode;
            end
            OP_SBC: begin
                drv_sums = 1'b1;
                drv_b    = dec_mode ? (8'h99 - src_b) : ~src_b;
                drv_cin  = src_cin;
                drv_dec  = dec_mode;
            end
            OP_AND: begin drv_ands = 1'b1; drv_b = src_b; end
            OP_ORA: begin drv_ors  = 1'b1; drv_b = src_b; end
            OP_EOR: begin drv_eors = 1'b1; drv_b = src_b; end
            OP_LSR, OP_ROR: begin drv_srs = 1'b1; drv_b = 8'h01; end
            OP_ASL: begin drv_sums = 1'b1; drv_b = src_a; end
            OP_ROL: begin drv_sums = 1'b1; drv_b = src_a; drv_cin = src_cin; end
            OP_CMP: begin drv_sums = 1'b1; drv_b = ~src_b; drv_cin = 1'b1; end
            default: drv_a = 8'h00;
        endcase
    end

    always_comb begin
        op_legal = (op_q <= OP_CMP);
        fin_res  = ALU_RESULT;
        fin_c    = C;
        fin_v    = V;
        if (op_q == OP_ROR) fin_res[7] = cin_q;
        case (op_q)
            OP_ADC, OP_SBC: begin fin_c = ALU_COUT; fin_v = ALU_OF; end
            OP_ASL, OP_ROL, OP_CMP: fin_c = ALU_COUT;
            OP_LSR, OP_ROR: fin_c = opa_q[0];
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            op_q    <= 4'd0;
            opa_q   <= 8'h00;
            opb_q   <= 8'h00;
            cin_q   <= 1'b0;
            dflag_q <= 1'b0;
            ALU_A   <= 8'h00;
            ALU_B   <= 8'h00;
            ALU_CIN <= 1'b0;
            SUMS    <= 1'b0;
            ANDS    <= 1'b0;
            ORS     <= 1'b0;
            EORS    <= 1'b0;
            SRS     <= 1'b0;
            DEC_EN  <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
            WE      <= 1'b0;
            ERR     <= 1'b0;
            RESULT  <= 8'h00;
            N       <= 1'b0;
            Z       <= 1'b0;
            C       <= 1'b0;
            V       <= 1'b0;
        end else begin
            if (state == S_IDLE && REQ) begin
                op_q    <= OP;
                opa_q   <= OPA;
                opb_q   <= OPB;
                cin_q   <= C_IN;
                dflag_q <= D_FLAG;
            end
            ALU_A   <= drive_active ? drv_a : 8'h00;
            ALU_B   <= drive_active ? drv_b : 8'h00;
            ALU_CIN <= drive_active && drv_cin;
            SUMS    <= drive_active && drv_sums;
            ANDS    <= drive_active && drv_ands;
            ORS     <= drive_active && drv_ors;
            EORS    <= drive_active && drv_eors;
            SRS     <= drive_active && drv_srs;
            DEC_EN  <= drive_active && drv_dec;
            BUSY    <= (next_state != S_IDLE);
            DONE    <= (next_state == S_DONE);
            WE      <= (state == S_EXEC) && op_legal && (op_q != OP_CMP);
            ERR     <= (state == S_EXEC) && !op_legal;
            if (state == S_EXEC && op_legal) begin
                RESULT <= fin_res;
                N      <= fin_res[7];
                Z      <= (fin_res == 8'h00);
                C      <= fin_c;
                V      <= fin_v;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed plus random checks of alu_sequencer against an arithmetic model
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N, REQ, C_IN, D_FLAG;
    logic [3:0] OP;
    logic [7:0] OPA, OPB;
    logic [7:0] ALU_A, ALU_B, ALU_RESULT, RESULT;
    logic       ALU_CIN, SUMS, ANDS, ORS, EORS, SRS, DEC_EN, ALU_COUT, ALU_OF;
    logic       BUSY, DONE, WE, ERR, N, Z, C, V;
    logic [4:0] sel;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_res;
    logic       m_n, m_z, m_c, m_v;

    always #5 CLK = ~CLK;

    alu_sequencer #(.DEC_SUPPORT(1)) dut (
        .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .OP(OP), .OPA(OPA), .OPB(OPB),
        .C_IN(C_IN), .D_FLAG(D_FLAG),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_CIN(ALU_CIN),
        .SUMS(SUMS), .ANDS(ANDS), .ORS(ORS), .EORS(EORS), .SRS(SRS), .DEC_EN(DEC_EN),
        .ALU_RESULT(ALU_RESULT), .ALU_COUT(ALU_COUT), .ALU_OF(ALU_OF),
        .BUSY(BUSY), .DONE(DONE), .WE(WE), .ERR(ERR), .RESULT(RESULT),
        .N(N), .Z(Z), .C(C), .V(V)
    );

    assign sel = {SUMS, ANDS, ORS, EORS, SRS};

    function automatic int bcd2i(input logic [7:0] x);
        return int'(x[7:4]) * 10 + int'(x[3:0]);
    endfunction

    function automatic logic [7:0] i2bcd(input int n);
        logic [3:0] t, u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    // Stand-in for the external ALU: decimal adds report OF=1 so V capture is observable.
    function automatic logic [9:0] alu_stub(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                            input logic [4:0] s, input logic dec);
        logic [8:0] t;
        int         d;
        if (s[4] && dec) begin
            d = bcd2i(a) + bcd2i(b) + int'(cin);
            return {1'b1, d >= 100, i2bcd(d % 100)};
        end
        if (s[4]) begin
            t = {1'b0, a} + {1'b0, b} + {8'h00, cin};
            return {(a[7] == b[7]) && (t[7] != a[7]), t[8], t[7:0]};
        end
        if (s[3]) return {2'b00, a & b};
        if (s[2]) return {2'b00, a | b};
        if (s[1]) return {2'b00, a ^ b};
        if (s[0]) return {1'b0, a[0], a >> b};
        return 10'h000;
    endfunction

    assign {ALU_OF, ALU_COUT, ALU_RESULT} = alu_stub(ALU_A, ALU_B, ALU_CIN, sel, DEC_EN);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] exp_sel(input logic [3:0] op);
        case (op)
            4'd0, 4'd1, 4'd6, 4'd7, 4'd9: return 5'b10000;
            4'd2: return 5'b01000;
            4'd3: return 5'b00100;
            4'd4: return 5'b00010;
            4'd5, 4'd8: return 5'b00001;
            default: return 5'b00000;
        endcase
    endfunction

    task automatic model_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                            input logic cin, input logic d, output logic we, output logic err);
        int r, sa;
        r = 0;
        case (op)
            4'd0: if (d) begin
                      sa = bcd2i(a) + bcd2i(b) + int'(cin);
                      r = int'(i2bcd(sa % 100)); m_c = (sa >= 100); m_v = 1'b1;
                  end else begin
                      r = int'(a) + int'(b) + int'(cin); m_c = (r > 255);
                      sa = int'($signed(a)) + int'($signed(b)) + int'(cin);
                      m_v = (sa > 127) || (sa < -128);
                  end
            4'd1: if (d) begin
                      sa = bcd2i(a) - bcd2i(b) - (1 - int'(cin));
                      r = int'(i2bcd((sa + 100) % 100)); m_c = (sa >= 0); m_v = 1'b1;
                  end else begin
                      r = int'(a) - int'(b) - (1 - int'(cin)); m_c = (r >= 0);
                      sa = int'($signed(a)) - int'($signed(b)) - (1 - int'(cin));
                      m_v = (sa > 127) || (sa < -128);
                  end
            4'd2: r = int'(a & b);
            4'd3: r = int'(a | b);
            4'd4: r = int'(a ^ b);
            4'd5: begin r = int'(a) / 2; m_c = a[0]; end
            4'd6: begin r = int'(a) * 2; m_c = a[7]; end
            4'd7: begin r = int'(a) * 2 + int'(cin); m_c = a[7]; end
            4'd8: begin r = int'(a) / 2 + 128 * int'(cin); m_c = a[0]; end
            4'd9: begin r = int'(a) - int'(b); m_c = (a >= b); end
            default: ;
        endcase
        if (op <= 4'd9) begin
            m_res = 8'(r);
            m_n   = m_res[7];
            m_z   = (m_res == 8'h00);
            we    = (op != 4'd9);
            err   = 1'b0;
        end else begin
            we  = 1'b0;
            err = 1'b1;
        end
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge after returning to idle.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input logic cin, input logic d);
        logic ewe, eerr, edec;
        edec = d && (op <= 4'd1);
        RST_N = 1'b1; REQ = 1'b1; OP = op; OPA = a; OPB = b; C_IN = cin; D_FLAG = d;
        @(posedge CLK); @(negedge CLK);
        REQ = 1'b0; OP = 4'($urandom); OPA = 8'($urandom); OPB = 8'($urandom);
        C_IN = 1'($urandom); D_FLAG = 1'($urandom);
        check("load_busy", BUSY, 1);
        check("load_done", DONE, 0);
        check("load_sel", sel, exp_sel(op));
        check("load_dec", DEC_EN, edec);
        @(negedge CLK);
        check("exec_sel", sel, exp_sel(op));
        check("exec_dec", DEC_EN, edec);
        model_op(op, a, b, cin, d, ewe, eerr);
        @(negedge CLK);
        check("done_pulse", {BUSY, DONE}, 2'b11);
        check("done_we_err", {WE, ERR}, {ewe, eerr});
        check("done_result", RESULT, m_res);
        check("done_nzcv", {N, Z, C, V}, {m_n, m_z, m_c, m_v});
        check("done_ctl_idle", {ALU_A, ALU_B, ALU_CIN, sel, DEC_EN}, 0);
        @(negedge CLK);
        check("idle_busy_done", {BUSY, DONE}, 2'b00);
        check("idle_hold", {RESULT, N, Z, C, V}, {m_res, m_n, m_z, m_c, m_v});
    endtask

    logic [1:0] exp_bd [7] = '{2'b10, 2'b10, 2'b11, 2'b00, 2'b10, 2'b10, 2'b11};

    initial begin
        logic       w, e;
        logic [3:0] rop;
        logic       rd;
        RST_N = 1'b0; REQ = 1'b0; OP = 4'd0; OPA = 8'h00; OPB = 8'h00; C_IN = 1'b0; D_FLAG = 1'b0;
        m_res = 8'h00; {m_n, m_z, m_c, m_v} = 4'b0000;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_outputs", {BUSY, DONE, WE, ERR, RESULT, N, Z, C, V, ALU_A, ALU_B, ALU_CIN, sel, DEC_EN}, 0);

        run_op(4'd0, 8'h50, 8'h50, 1'b0, 1'b0);
        check("adc_5050_result", RESULT, 8'hA0);
        check("adc_5050_nzcv", {N, Z, C, V}, 4'b1001);
        run_op(4'd0, 8'h45, 8'h55, 1'b0, 1'b1);
        check("dec_adc_result", {RESULT, Z, C}, {8'h00, 2'b11});
        run_op(4'd8, 8'h01, 8'h00, 1'b1, 1'b0);
        check("ror_result", {RESULT, C, N}, {8'h80, 2'b11});
        run_op(4'd9, 8'h10, 8'h10, 1'b0, 1'b0);
        check("cmp_equal", {Z, C}, 2'b11);
        run_op(4'd1, 8'h50, 8'h21, 1'b1, 1'b1);

        RST_N = 1'b1; REQ = 1'b1; OP = 4'd2; OPA = 8'hF3; OPB = 8'h3C; C_IN = 1'b0; D_FLAG = 1'b0;
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            check($sformatf("b2b_busy_done_%0d", i), {BUSY, DONE}, exp_bd[i]);
        end
        REQ = 1'b0;
        model_op(4'd2, 8'hF3, 8'h3C, 1'b0, 1'b0, w, e);
        @(negedge CLK);
        check("b2b_final", {BUSY, RESULT}, {1'b0, 8'h30});

        REQ = 1'b1; OP = 4'd0; OPA = 8'h7F; OPB = 8'h01; C_IN = 1'b1;
        @(posedge CLK); @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        check("abort_outputs", {BUSY, DONE, WE, ERR, RESULT, N, Z, C, V, ALU_A, ALU_B, ALU_CIN, sel, DEC_EN}, 0);
        m_res = 8'h00; {m_n, m_z, m_c, m_v} = 4'b0000;
        run_op(4'd6, 8'hC1, 8'h00, 1'b1, 1'b0);
        run_op(4'd12, 8'h12, 8'h34, 1'b1, 1'b1);
        check("illegal_hold", {RESULT, N, Z, C, V}, {8'h82, 4'b1010});

        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            rd  = 1'($urandom);
            if (rd && rop <= 4'd1)
                run_op(rop, i2bcd($urandom_range(0, 99)), i2bcd($urandom_range(0, 99)), 1'($urandom), rd);
            else
                run_op(rop, 8'($urandom), 8'($urandom), 1'($urandom), rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
